// File: rtl/rom_bus_ctrl.sv
// rtl/rom_bus_ctrl.sv - SNES/MCU arbiter and timed cycle engine for the 16-bit ROM/PSRAM bus
module rom_bus_ctrl #(
    parameter int RD_WAIT = 5,
    parameter int WR_WAIT = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        snes_req,
    input  logic        snes_we,
    input  logic [23:0] snes_addr,
    input  logic        snes_hit,
    input  logic        snes_writable,
    input  logic [7:0]  snes_wdata,
    output logic [7:0]  snes_rdata,
    output logic        snes_done,
    input  logic        mcu_req,
    input  logic        mcu_we,
    input  logic [23:0] mcu_addr,
    input  logic [7:0]  mcu_wdata,
    output logic [7:0]  mcu_rdata,
    output logic        mcu_rdy,
    output logic [22:0] ROM_ADDR_o,
    output logic [15:0] ROM_DATA_o,
    output logic        ROM_DATA_oe,
    input  logic [15:0] ROM_DATA_i,
    output logic        ROM_CE_n,
    output logic        ROM_OE_n,
    output logic        ROM_WE_n,
    output logic        ROM_BHE_n,
    output logic        ROM_BLE_n,
    output logic        busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [3:0] RD_LOAD = 4'(RD_WAIT);
    localparam logic [3:0] WR_LOAD = 4'(WR_WAIT);

    logic [1:0]  state;
    logic [3:0]  wait_cnt;

    // Single-entry SNES request holding register
    logic        pend;
    logic        pend_we;
    logic [23:0] pend_addr;
    logic [7:0]  pend_wdata;
    logic        pend_writable;

    // Attributes of the cycle currently on the bus
    logic        cur_snes;
    logic        cur_we;
    logic        cur_wr_en;
    logic        cur_lane_hi;
    logic [7:0]  cur_wdata;

    logic        snes_new;
    logic        start_snes;
    logic        start_mcu;
    logic        lanes_on;
    logic [7:0]  rd_byte;

    assign snes_new   = snes_req && snes_hit;
    assign start_snes = (state == S_IDLE) && pend;
    // A fresh SNES request in the same cycle also blocks the MCU so SNES goes first
    assign start_mcu  = (state == S_IDLE) && !pend && !snes_new && mcu_req;

    // Latest SNES request wins; a new arrival beats the consume of the old one
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pend          <= 1'b0;
            pend_we       <= 1'b0;
            pend_addr     <= 24'd0;
            pend_wdata    <= 8'd0;
            pend_writable <= 1'b0;
        end else if (snes_new) begin
            pend          <= 1'b1;
            pend_we       <= snes_we;
            pend_addr     <= snes_addr;
            pend_wdata    <= snes_wdata;
            pend_writable <= snes_writable;
        end else if (start_snes) begin
            pend          <= 1'b0;
        end
    end

    assign rd_byte = cur_lane_hi ? ROM_DATA_i[15:8] : ROM_DATA_i[7:0];

    // Cycle sequencer: launch, time the strobes, capture read data
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= S_IDLE;
            wait_cnt    <= 4'd0;
            cur_snes    <= 1'b0;
            cur_we      <= 1'b0;
            cur_wr_en   <= 1'b0;
            cur_lane_hi <= 1'b0;
            cur_wdata   <= 8'd0;
            ROM_ADDR_o  <= 23'd0;
            snes_rdata  <= 8'd0;
            mcu_rdata   <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_snes) begin
                        cur_snes    <= 1'b1;
                        cur_we      <= pend_we;
                        cur_wr_en   <= pend_writable;
                        cur_lane_hi <= pend_addr[0];
                        cur_wdata   <= pend_wdata;
                        ROM_ADDR_o  <= pend_addr[23:1];
                        state       <= pend_we ? S_WR : S_RD;
                        wait_cnt    <= pend_we ? WR_LOAD : RD_LOAD;
                    end else if (start_mcu) begin
                        cur_snes    <= 1'b0;
                        cur_we      <= mcu_we;
                        cur_wr_en   <= 1'b1;
                        cur_lane_hi <= mcu_addr[0];
                        cur_wdata   <= mcu_wdata;
                        ROM_ADDR_o  <= mcu_addr[23:1];
                        state       <= mcu_we ? S_WR : S_RD;
                        wait_cnt    <= mcu_we ? WR_LOAD : RD_LOAD;
                    end
                end
                S_RD: begin
                    if (wait_cnt == 4'd1) begin
                        if (cur_snes) begin
                            snes_rdata <= rd_byte;
                        end else begin
                            mcu_rdata  <= rd_byte;
                        end
                        state <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_WR: begin
                    if (wait_cnt == 4'd1) begin
                        state <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Strobes decode straight from registered state so reset releases them at once
    always_comb begin
        busy        = (state != S_IDLE);
        lanes_on    = busy && (!cur_we || cur_wr_en);
        ROM_OE_n    = !(state == S_RD);
        ROM_WE_n    = !((state == S_WR) && cur_wr_en);
        ROM_CE_n    = !((state == S_RD) || ((state == S_WR) && cur_wr_en));
        ROM_DATA_oe = ((state == S_WR) || (state == S_DONE)) && cur_we && cur_wr_en;
        ROM_BHE_n   = !(lanes_on && cur_lane_hi);
        ROM_BLE_n   = !(lanes_on && !cur_lane_hi);
        ROM_DATA_o  = {cur_wdata, cur_wdata};
        snes_done   = (state == S_DONE) && cur_snes;
        mcu_rdy     = (state == S_DONE) && !cur_snes;
    end

endmodule

// File: tb/tb_rom_bus_ctrl.sv
// tb/tb_rom_bus_ctrl.sv - directed self-checking bench for rom_bus_ctrl
module tb_rom_bus_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        snes_req = 0, snes_we = 0, snes_hit = 0, snes_writable = 0;
    logic [23:0] snes_addr = 0;
    logic [7:0]  snes_wdata = 0;
    logic [7:0]  snes_rdata;
    logic        snes_done;
    logic        mcu_req = 0, mcu_we = 0;
    logic [23:0] mcu_addr = 0;
    logic [7:0]  mcu_wdata = 0;
    logic [7:0]  mcu_rdata;
    logic        mcu_rdy;
    logic [22:0] ROM_ADDR_o;
    logic [15:0] ROM_DATA_o;
    logic        ROM_DATA_oe;
    logic [15:0] ROM_DATA_i;
    logic        ROM_CE_n, ROM_OE_n, ROM_WE_n, ROM_BHE_n, ROM_BLE_n;
    logic        busy;

    logic        use_model = 0;
    logic [15:0] rom_fixed = 16'h0000;

    int total = 0;
    int bad   = 0;

    // Monitor state, cycle index k counts clock edges since the accepting edge
    int cyc, oe_low, we_low, we_last, oe_on, oe_last, conflict, ce_fall;
    int done_cnt, done_at, rdy_cnt, rdy_at, busy_cnt, addr_chg;
    logic [22:0] fall_addr, prev_addr;
    logic [7:0]  rdy_data;
    logic        prev_ce, prev_busy;

    always #5 CLK = ~CLK;

    // Memory model: low byte = word address LSBs, high byte = its inverse
    assign ROM_DATA_i = use_model ? {~ROM_ADDR_o[7:0], ROM_ADDR_o[7:0]} : rom_fixed;

    rom_bus_ctrl #(.RD_WAIT(5), .WR_WAIT(4)) dut (
        .CLK(CLK), .RST(RST),
        .snes_req(snes_req), .snes_we(snes_we), .snes_addr(snes_addr),
        .snes_hit(snes_hit), .snes_writable(snes_writable), .snes_wdata(snes_wdata),
        .snes_rdata(snes_rdata), .snes_done(snes_done),
        .mcu_req(mcu_req), .mcu_we(mcu_we), .mcu_addr(mcu_addr),
        .mcu_wdata(mcu_wdata), .mcu_rdata(mcu_rdata), .mcu_rdy(mcu_rdy),
        .ROM_ADDR_o(ROM_ADDR_o), .ROM_DATA_o(ROM_DATA_o), .ROM_DATA_oe(ROM_DATA_oe),
        .ROM_DATA_i(ROM_DATA_i), .ROM_CE_n(ROM_CE_n), .ROM_OE_n(ROM_OE_n),
        .ROM_WE_n(ROM_WE_n), .ROM_BHE_n(ROM_BHE_n), .ROM_BLE_n(ROM_BLE_n),
        .busy(busy)
    );

    always @(negedge CLK) begin
        if (!ROM_OE_n) oe_low++;
        if (!ROM_WE_n) begin we_low++; we_last = cyc; end
        if (!ROM_OE_n && !ROM_WE_n) conflict++;
        if (ROM_DATA_oe) begin oe_on++; oe_last = cyc; end
        if (prev_ce && !ROM_CE_n) begin ce_fall++; fall_addr = ROM_ADDR_o; end
        if (snes_done) begin done_cnt++; if (done_at < 0) done_at = cyc; end
        if (mcu_rdy) begin rdy_cnt++; if (rdy_at < 0) rdy_at = cyc; rdy_data = mcu_rdata; end
        if (busy) busy_cnt++;
        if (busy && prev_busy && ROM_ADDR_o != prev_addr) addr_chg++;
        prev_ce   = ROM_CE_n;
        prev_busy = busy;
        prev_addr = ROM_ADDR_o;
        cyc++;
    end

    task automatic clear_mon();
        cyc = 0; oe_low = 0; we_low = 0; we_last = -1; oe_on = 0; oe_last = -1;
        conflict = 0; ce_fall = 0; done_cnt = 0; done_at = -1; rdy_cnt = 0;
        rdy_at = -1; busy_cnt = 0; addr_chg = 0; fall_addr = 0; rdy_data = 0;
        prev_ce = ROM_CE_n; prev_busy = busy; prev_addr = ROM_ADDR_o;
    endtask

    // Drives a one-cycle SNES pulse; called and returns at posedge+1
    task automatic snes_pulse(input logic we, input logic [23:0] a, input logic hit,
                              input logic wr, input logic [7:0] d);
        snes_req = 1; snes_we = we; snes_addr = a; snes_hit = hit;
        snes_writable = wr; snes_wdata = d;
        @(posedge CLK); #1;
        snes_req = 0;
    endtask

    task automatic test_reset();
        #12;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        total++; if ({ROM_CE_n, ROM_OE_n, ROM_WE_n, ROM_BHE_n, ROM_BLE_n} !== 5'b11111) begin
            bad++; $display("FAIL rst_strobes got=%b want=11111", {ROM_CE_n, ROM_OE_n, ROM_WE_n, ROM_BHE_n, ROM_BLE_n}); end
        total++; if ({ROM_DATA_oe, snes_done, mcu_rdy} !== 3'b000) begin
            bad++; $display("FAIL rst_pulses got=%b want=000", {ROM_DATA_oe, snes_done, mcu_rdy}); end
        total++; if ({snes_rdata, mcu_rdata, ROM_ADDR_o} !== 39'd0) begin
            bad++; $display("FAIL rst_regs got=%h want=0", {snes_rdata, mcu_rdata, ROM_ADDR_o}); end
        @(negedge CLK); RST = 0;
        @(posedge CLK); #1;
    endtask

    task automatic test_snes_read();
        use_model = 0; rom_fixed = 16'hA55A;
        snes_pulse(1'b0, 24'h123457, 1'b1, 1'b0, 8'h00);
        clear_mon();
        @(negedge CLK); @(negedge CLK);
        total++; if (ROM_ADDR_o !== 23'h091A2B) begin bad++; $display("FAIL rd_addr got=%h want=091a2b", ROM_ADDR_o); end
        total++; if ({ROM_BHE_n, ROM_BLE_n, ROM_OE_n} !== 3'b010) begin
            bad++; $display("FAIL rd_lanes got=%b want=010", {ROM_BHE_n, ROM_BLE_n, ROM_OE_n}); end
        repeat (10) @(negedge CLK);
        total++; if (oe_low !== 5) begin bad++; $display("FAIL rd_oe_len got=%0d want=5", oe_low); end
        total++; if (done_at !== 6 || done_cnt !== 1) begin
            bad++; $display("FAIL rd_done got_at=%0d cnt=%0d want_at=6 cnt=1", done_at, done_cnt); end
        total++; if (snes_rdata !== 8'hA5) begin bad++; $display("FAIL rd_data got=%h want=a5", snes_rdata); end
        total++; if (addr_chg !== 0 || conflict !== 0) begin
            bad++; $display("FAIL rd_stable got=%0d/%0d want=0/0", addr_chg, conflict); end
        @(posedge CLK); #1;
    endtask

    task automatic test_snes_write();
        snes_pulse(1'b1, 24'hE00010, 1'b1, 1'b1, 8'h3C);
        clear_mon();
        @(negedge CLK); @(negedge CLK);
        total++; if (ROM_DATA_o !== 16'h3C3C) begin bad++; $display("FAIL wr_data got=%h want=3c3c", ROM_DATA_o); end
        total++; if ({ROM_BHE_n, ROM_BLE_n, ROM_WE_n} !== 3'b100) begin
            bad++; $display("FAIL wr_lanes got=%b want=100", {ROM_BHE_n, ROM_BLE_n, ROM_WE_n}); end
        total++; if (ROM_ADDR_o !== 23'h700008) begin bad++; $display("FAIL wr_addr got=%h want=700008", ROM_ADDR_o); end
        repeat (10) @(negedge CLK);
        total++; if (we_low !== 4) begin bad++; $display("FAIL wr_we_len got=%0d want=4", we_low); end
        total++; if (oe_on !== 5 || oe_last - we_last !== 1) begin
            bad++; $display("FAIL wr_oe_hold got=%0d/%0d want=5/1", oe_on, oe_last - we_last); end
        total++; if (done_at !== 5) begin bad++; $display("FAIL wr_done got=%0d want=5", done_at); end
        @(posedge CLK); #1;
        snes_pulse(1'b1, 24'hE00010, 1'b1, 1'b0, 8'h3C);
        clear_mon();
        repeat (12) @(negedge CLK);
        total++; if (we_low !== 0 || oe_on !== 0 || ce_fall !== 0) begin
            bad++; $display("FAIL wp_strobes got=%0d/%0d/%0d want=0/0/0", we_low, oe_on, ce_fall); end
        total++; if (done_at !== 5 || busy_cnt !== 5) begin
            bad++; $display("FAIL wp_done got=%0d/%0d want=5/5", done_at, busy_cnt); end
        @(posedge CLK); #1;
    endtask

    task automatic test_arbitration();
        logic got;
        got = 0;
        use_model = 1;
        mcu_req = 1; mcu_we = 0; mcu_addr = 24'h000201;
        snes_pulse(1'b0, 24'h000100, 1'b1, 1'b0, 8'h00);
        clear_mon();
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge CLK);
            if (mcu_rdy) got = 1;
        end
        total++; if (got !== 1'b1) begin bad++; $display("FAIL arb_timeout got=%b want=1", got); end
        @(posedge CLK); #1;
        mcu_req = 0;
        repeat (6) @(negedge CLK);
        total++; if (done_at !== 6 || rdy_at !== 13) begin
            bad++; $display("FAIL arb_order got=%0d/%0d want=6/13", done_at, rdy_at); end
        total++; if (snes_rdata !== 8'h80 || rdy_data !== 8'hFF) begin
            bad++; $display("FAIL arb_data got=%h/%h want=80/ff", snes_rdata, rdy_data); end
        total++; if (ce_fall !== 2 || rdy_cnt !== 1) begin
            bad++; $display("FAIL arb_cycles got=%0d/%0d want=2/1", ce_fall, rdy_cnt); end
        @(posedge CLK); #1;
    endtask

    task automatic test_back_to_back();
        use_model = 1;
        snes_pulse(1'b0, 24'h000010, 1'b1, 1'b0, 8'h00);
        clear_mon();
        @(posedge CLK); #1;
        snes_pulse(1'b0, 24'h000020, 1'b1, 1'b0, 8'h00);
        snes_pulse(1'b0, 24'h000031, 1'b1, 1'b0, 8'h00);
        repeat (16) @(negedge CLK);
        total++; if (ce_fall !== 2 || done_cnt !== 2) begin
            bad++; $display("FAIL b2b_cycles got=%0d/%0d want=2/2", ce_fall, done_cnt); end
        total++; if (fall_addr !== 23'h000018 || snes_rdata !== 8'hE7) begin
            bad++; $display("FAIL b2b_latest got=%h/%h want=000018/e7", fall_addr, snes_rdata); end
        @(posedge CLK); #1;
        snes_pulse(1'b0, 24'h000040, 1'b0, 1'b0, 8'h00);
        clear_mon();
        repeat (8) @(negedge CLK);
        total++; if (busy_cnt !== 0 || done_cnt !== 0) begin
            bad++; $display("FAIL miss_ignored got=%0d/%0d want=0/0", busy_cnt, done_cnt); end
        @(posedge CLK); #1;
    endtask

    task automatic test_reset_mid();
        use_model = 1;
        snes_pulse(1'b0, 24'h000100, 1'b1, 1'b0, 8'h00);
        clear_mon();
        @(posedge CLK); #1;
        snes_pulse(1'b0, 24'h000200, 1'b1, 1'b0, 8'h00);
        @(posedge CLK); #1;
        RST = 1;
        #1;
        total++; if ({ROM_CE_n, ROM_OE_n, busy} !== 3'b110) begin
            bad++; $display("FAIL mid_rst got=%b want=110", {ROM_CE_n, ROM_OE_n, busy}); end
        @(negedge CLK); RST = 0;
        repeat (10) @(negedge CLK);
        total++; if (done_cnt !== 0 || busy !== 1'b0) begin
            bad++; $display("FAIL mid_lost got=%0d/%b want=0/0", done_cnt, busy); end
        @(posedge CLK); #1;
        snes_pulse(1'b0, 24'h000004, 1'b1, 1'b0, 8'h00);
        clear_mon();
        repeat (10) @(negedge CLK);
        total++; if (done_at !== 6 || snes_rdata !== 8'h02) begin
            bad++; $display("FAIL mid_recover got=%0d/%h want=6/02", done_at, snes_rdata); end
        @(posedge CLK); #1;
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_snes_read();
        test_snes_write();
        test_arbitration();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
